// File: rtl/uart_frame_rx_pkg.sv
// Shared constants, state types and field range rules for the status-link receiver.
// The link defaults here are also used by the transmitter on the other board.
package uart_frame_rx_pkg;

    localparam int CLK_FREQ_DEF  = 100_000_000;
    localparam int BAUD_RATE_DEF = 9600;

    localparam logic [7:0] SYNC_BYTE = 8'hFF;
    localparam int         FRAME_LEN = 8;

    localparam logic [2:0] IDX_STATE = 3'd0;
    localparam logic [2:0] IDX_CHOUR = 3'd1;
    localparam logic [2:0] IDX_CMIN  = 3'd2;
    localparam logic [2:0] IDX_CSEC  = 3'd3;
    localparam logic [2:0] IDX_WHOUR = 3'd4;
    localparam logic [2:0] IDX_WMIN  = 3'd5;
    localparam logic [2:0] IDX_WSEC  = 3'd6;

    localparam logic [7:0] MAX_HOUR   = 8'd24;
    localparam logic [7:0] MAX_MINSEC = 8'd60;

    typedef enum logic [2:0] {
        BYTE_IDLE,
        BYTE_START,
        BYTE_DATA,
        BYTE_STOP,
        BYTE_BREAK
    } byte_state_e;

    typedef enum logic {
        FRAME_HUNT,
        FRAME_PAYLOAD
    } frame_state_e;

    // Working hours are only limited by the 6-bit field width.
    function automatic logic fieldInRange(input logic [2:0] idx, input logic [7:0] value);
        logic ok;
        ok = 1'b1;
        case (idx)
            IDX_STATE: ok = (value[7:3] == 5'd0);
            IDX_CHOUR: ok = (value < MAX_HOUR);
            IDX_WHOUR: ok = (value[7:6] == 2'd0);
            default:   ok = (value < MAX_MINSEC);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Serial input and decoded status fields of the frame receiver.
// The slave side is the receiver itself; the master side drives rx and consumes the fields.
interface uart_frame_rx_if;

    logic       rx;
    logic [2:0] state_out;
    logic [5:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [5:0] work_hour;
    logic [5:0] work_min;
    logic [5:0] work_sec;
    logic       frame_valid;
    logic       frame_err;

    modport master (
        output rx,
        input  state_out, cur_hour, cur_min, cur_sec,
        input  work_hour, work_min, work_sec,
        input  frame_valid, frame_err
    );

    modport slave (
        input  rx,
        output state_out, cur_hour, cur_min, cur_sec,
        output work_hour, work_min, work_sec,
        output frame_valid, frame_err
    );

endinterface

// File: rtl/uart_frame_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser on rx, mid-bit sampling, LSB first.
// A low stop bit is reported as byteErr_o and the line must return high before the next byte.
module uart_rx_byte
    import uart_frame_rx_pkg::*;
#(
    parameter int DIVISOR = CLK_FREQ_DEF / BAUD_RATE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byteValid_o,
    output logic       byteErr_o
);

    localparam int CNT_W = ($clog2(DIVISOR + 1) > 14) ? $clog2(DIVISOR + 1) : 14;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIVISOR - 1);

    logic             rxMeta_q, rxSync_q;
    byte_state_e      state_q, state_d;
    logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
    logic [2:0]       bitCnt_q, bitCnt_d;
    logic [7:0]       shreg_q, shreg_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxMeta_q  <= 1'b1;
            rxSync_q  <= 1'b1;
            state_q   <= BYTE_IDLE;
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            shreg_q   <= '0;
        end else begin
            rxMeta_q  <= rx_i;
            rxSync_q  <= rxMeta_q;
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitCnt_q  <= bitCnt_d;
            shreg_q   <= shreg_d;
        end
    end

    // The start bit is re-checked at its middle so short glitches fall back to idle.
    always_comb begin
        state_d     = state_q;
        baudCnt_d   = baudCnt_q;
        bitCnt_d    = bitCnt_q;
        shreg_d     = shreg_q;
        byteValid_o = 1'b0;
        byteErr_o   = 1'b0;
        case (state_q)
            BYTE_IDLE: begin
                if (!rxSync_q) begin
                    state_d   = BYTE_START;
                    baudCnt_d = '0;
                end
            end
            BYTE_START: begin
                if (baudCnt_q == HALF_LAST) begin
                    baudCnt_d = '0;
                    bitCnt_d  = '0;
                    state_d   = rxSync_q ? BYTE_IDLE : BYTE_DATA;
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            BYTE_DATA: begin
                if (baudCnt_q == BIT_LAST) begin
                    baudCnt_d = '0;
                    shreg_d   = {rxSync_q, shreg_q[7:1]};
                    bitCnt_d  = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = BYTE_STOP;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            BYTE_STOP: begin
                if (baudCnt_q == BIT_LAST) begin
                    baudCnt_d = '0;
                    if (rxSync_q) begin
                        byteValid_o = 1'b1;
                        state_d     = BYTE_IDLE;
                    end else begin
                        byteErr_o = 1'b1;
                        state_d   = BYTE_BREAK;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            BYTE_BREAK: begin
                if (rxSync_q) begin
                    state_d = BYTE_IDLE;
                end
            end
            default: state_d = BYTE_IDLE;
        endcase
    end

    assign byte_o = shreg_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Status-link frame receiver: hunts for the sync byte, range-checks the seven payload
// fields into shadow registers and publishes them all at once on a complete good frame.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int CLK_FREQ  = CLK_FREQ_DEF,
    parameter int BAUD_RATE = BAUD_RATE_DEF,
    parameter int DIVISOR   = CLK_FREQ / BAUD_RATE,
    parameter int GAP_BYTES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_frame_rx_if.slave  link
);

    localparam int GAP_LIMIT = GAP_BYTES * 10 * DIVISOR;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
    // Registered error lands exactly GAP_LIMIT cycles after the strobe that cleared the counter.
    localparam logic [GAP_W-1:0] GAP_MATCH = GAP_W'(GAP_LIMIT - 2);

    logic [7:0] rxByte;
    logic       byteValid, byteErr;

    uart_rx_byte #(.DIVISOR(DIVISOR)) u_byte (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (link.rx),
        .byte_o      (rxByte),
        .byteValid_o (byteValid),
        .byteErr_o   (byteErr)
    );

    frame_state_e     frameState_q, frameState_d;
    logic [2:0]       idx_q, idx_d;
    logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
    logic [2:0]       shState_q, shState_d;
    logic [5:0]       shCurHour_q, shCurHour_d, shCurMin_q, shCurMin_d, shCurSec_q, shCurSec_d;
    logic [5:0]       shWorkHour_q, shWorkHour_d, shWorkMin_q, shWorkMin_d;
    logic [2:0]       stateOut_q, stateOut_d;
    logic [5:0]       curHour_q, curHour_d, curMin_q, curMin_d, curSec_q, curSec_d;
    logic [5:0]       workHour_q, workHour_d, workMin_q, workMin_d, workSec_q, workSec_d;
    logic             frameValid_q, frameValid_d, frameErr_q, frameErr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frameState_q <= FRAME_HUNT;
            idx_q        <= '0;
            gapCnt_q     <= '0;
            shState_q    <= '0;
            shCurHour_q  <= '0;
            shCurMin_q   <= '0;
            shCurSec_q   <= '0;
            shWorkHour_q <= '0;
            shWorkMin_q  <= '0;
            stateOut_q   <= '0;
            curHour_q    <= '0;
            curMin_q     <= '0;
            curSec_q     <= '0;
            workHour_q   <= '0;
            workMin_q    <= '0;
            workSec_q    <= '0;
            frameValid_q <= 1'b0;
            frameErr_q   <= 1'b0;
        end else begin
            frameState_q <= frameState_d;
            idx_q        <= idx_d;
            gapCnt_q     <= gapCnt_d;
            shState_q    <= shState_d;
            shCurHour_q  <= shCurHour_d;
            shCurMin_q   <= shCurMin_d;
            shCurSec_q   <= shCurSec_d;
            shWorkHour_q <= shWorkHour_d;
            shWorkMin_q  <= shWorkMin_d;
            stateOut_q   <= stateOut_d;
            curHour_q    <= curHour_d;
            curMin_q     <= curMin_d;
            curSec_q     <= curSec_d;
            workHour_q   <= workHour_d;
            workMin_q    <= workMin_d;
            workSec_q    <= workSec_d;
            frameValid_q <= frameValid_d;
            frameErr_q   <= frameErr_d;
        end
    end

    // A sync byte inside the payload means the sender restarted, so resync rather than hunt.
    always_comb begin
        frameState_d = frameState_q;
        idx_d        = idx_q;
        gapCnt_d     = gapCnt_q;
        shState_d    = shState_q;
        shCurHour_d  = shCurHour_q;
        shCurMin_d   = shCurMin_q;
        shCurSec_d   = shCurSec_q;
        shWorkHour_d = shWorkHour_q;
        shWorkMin_d  = shWorkMin_q;
        stateOut_d   = stateOut_q;
        curHour_d    = curHour_q;
        curMin_d     = curMin_q;
        curSec_d     = curSec_q;
        workHour_d   = workHour_q;
        workMin_d    = workMin_q;
        workSec_d    = workSec_q;
        frameValid_d = 1'b0;
        frameErr_d   = 1'b0;
        case (frameState_q)
            FRAME_HUNT: begin
                gapCnt_d = '0;
                if (byteErr) begin
                    frameErr_d = 1'b1;
                end else if (byteValid && rxByte == SYNC_BYTE) begin
                    frameState_d = FRAME_PAYLOAD;
                    idx_d        = '0;
                end
            end
            FRAME_PAYLOAD: begin
                if (byteErr) begin
                    frameErr_d   = 1'b1;
                    frameState_d = FRAME_HUNT;
                end else if (byteValid) begin
                    gapCnt_d = '0;
                    if (rxByte == SYNC_BYTE) begin
                        frameErr_d = 1'b1;
                        idx_d      = '0;
                    end else if (!fieldInRange(idx_q, rxByte)) begin
                        frameErr_d   = 1'b1;
                        frameState_d = FRAME_HUNT;
                    end else if (idx_q == IDX_WSEC) begin
                        frameValid_d = 1'b1;
                        frameState_d = FRAME_HUNT;
                        stateOut_d   = shState_q;
                        curHour_d    = shCurHour_q;
                        curMin_d     = shCurMin_q;
                        curSec_d     = shCurSec_q;
                        workHour_d   = shWorkHour_q;
                        workMin_d    = shWorkMin_q;
                        workSec_d    = rxByte[5:0];
                    end else begin
                        idx_d = idx_q + 3'd1;
                        case (idx_q)
                            IDX_STATE: shState_d    = rxByte[2:0];
                            IDX_CHOUR: shCurHour_d  = rxByte[5:0];
                            IDX_CMIN:  shCurMin_d   = rxByte[5:0];
                            IDX_CSEC:  shCurSec_d   = rxByte[5:0];
                            IDX_WHOUR: shWorkHour_d = rxByte[5:0];
                            default:   shWorkMin_d  = rxByte[5:0];
                        endcase
                    end
                end else if (gapCnt_q == GAP_MATCH) begin
                    frameErr_d   = 1'b1;
                    frameState_d = FRAME_HUNT;
                end else begin
                    gapCnt_d = gapCnt_q + 1'b1;
                end
            end
            default: frameState_d = FRAME_HUNT;
        endcase
    end

    assign link.state_out   = stateOut_q;
    assign link.cur_hour    = curHour_q;
    assign link.cur_min     = curMin_q;
    assign link.cur_sec     = curSec_q;
    assign link.work_hour   = workHour_q;
    assign link.work_min    = workMin_q;
    assign link.work_sec    = workSec_q;
    assign link.frame_valid = frameValid_q;
    assign link.frame_err   = frameErr_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Frame-level bench for uart_frame_rx with a fast 16-cycle bit time; expected fields and
// pulse counts come from a plain-arithmetic model of the frame rules.
module tb_uart_frame_rx;

    localparam int DIV        = 16;
    localparam int BAUD       = 9600;
    localparam int GAP_BYTES  = 2;
    localparam int GAP_CYCLES = GAP_BYTES * 10 * DIV;
    // Edge index of the byte strobe, counted from the first edge that sees the start bit:
    // two synchroniser stages, half a bit to the start-bit middle, then nine full bits.
    localparam int STROBE_DELAY = 2 + DIV / 2 + 9 * DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_frame_rx_if link();

    uart_frame_rx #(
        .CLK_FREQ  (DIV * BAUD),
        .BAUD_RATE (BAUD),
        .GAP_BYTES (GAP_BYTES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (link)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cycleCnt = 0;
    int fvCount = 0;
    int errCount = 0;
    int lastFvCyc = -1;
    int lastErrCyc = -1;
    int bothHigh = 0;
    int lastStartCyc = 0;
    int byteStart [8];
    logic [38:0] expFields = '0;

    always @(posedge clk) cycleCnt++;

    always @(negedge clk) begin
        if (link.frame_valid === 1'b1) begin
            fvCount++;
            lastFvCyc = cycleCnt;
        end
        if (link.frame_err === 1'b1) begin
            errCount++;
            lastErrCyc = cycleCnt;
        end
        if (link.frame_valid === 1'b1 && link.frame_err === 1'b1) bothHigh++;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [38:0] obsFields();
        return {link.state_out, link.cur_hour, link.cur_min, link.cur_sec,
                link.work_hour, link.work_min, link.work_sec};
    endfunction

    function automatic logic [38:0] fieldsOf(input logic [7:0][7:0] f);
        return {f[1][2:0], f[2][5:0], f[3][5:0], f[4][5:0], f[5][5:0], f[6][5:0], f[7][5:0]};
    endfunction

    function automatic bit frameGood(input logic [7:0][7:0] f);
        return (f[0] == 8'hFF) && (f[1] < 8) && (f[2] < 24) && (f[3] < 60) && (f[4] < 60)
               && (f[5] < 64) && (f[6] < 60) && (f[7] < 60);
    endfunction

    function automatic logic [7:0][7:0] randomGoodFrame();
        logic [7:0][7:0] f;
        f[0] = 8'hFF;
        f[1] = 8'($urandom_range(0, 7));
        f[2] = 8'($urandom_range(0, 23));
        f[3] = 8'($urandom_range(0, 59));
        f[4] = 8'($urandom_range(0, 59));
        f[5] = 8'($urandom_range(0, 63));
        f[6] = 8'($urandom_range(0, 59));
        f[7] = 8'($urandom_range(0, 59));
        return f;
    endfunction

    task automatic sendBits(input logic [7:0] b, input logic stopLevel);
        @(negedge clk);
        link.rx = 1'b0;
        lastStartCyc = cycleCnt;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            link.rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        link.rx = stopLevel;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0][7:0] f);
        for (int i = 0; i < 8; i++) begin
            sendBits(f[i], 1'b1);
            byteStart[i] = lastStartCyc;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        link.rx = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (obsFields() !== 39'd0) $display("[TB] FAIL reset_fields: got %h, required 0", obsFields());
        else passes++;
        checks++;
        if ({link.frame_valid, link.frame_err} !== 2'b00)
            $display("[TB] FAIL reset_pulses: got %b, required 00", {link.frame_valid, link.frame_err});
        else passes++;
        rst_n = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        checks++;
        if (fvCount + errCount !== 0) $display("[TB] FAIL idle_pulses: got %0d, required 0", fvCount + errCount);
        else passes++;
    endtask

    task automatic test_basic();
        logic [7:0][7:0] f;
        int fv0, er0;
        f = {8'h3B, 8'h1E, 8'h01, 8'h05, 8'h22, 8'h0C, 8'h03, 8'hFF};
        fv0 = fvCount; er0 = errCount;
        sendFrame(f);
        expFields = {3'd3, 6'd12, 6'd34, 6'd5, 6'd1, 6'd30, 6'd59};
        checks++;
        if (fvCount - fv0 !== 1) $display("[TB] FAIL basic_valid_count: got %0d, required 1", fvCount - fv0);
        else passes++;
        checks++;
        if (errCount - er0 !== 0) $display("[TB] FAIL basic_err_count: got %0d, required 0", errCount - er0);
        else passes++;
        checks++;
        if (obsFields() !== expFields) $display("[TB] FAIL basic_fields: got %h, required %h", obsFields(), expFields);
        else passes++;
        checks++;
        if (lastFvCyc !== byteStart[7] + STROBE_DELAY + 1)
            $display("[TB] FAIL basic_latency: got cycle %0d, required %0d", lastFvCyc, byteStart[7] + STROBE_DELAY + 1);
        else passes++;
    endtask

    task automatic test_range_error();
        logic [7:0][7:0] f;
        int fv0, er0;
        f = {8'h3B, 8'h1E, 8'h01, 8'h05, 8'h3C, 8'h0C, 8'h03, 8'hFF};
        fv0 = fvCount; er0 = errCount;
        sendFrame(f);
        checks++;
        if (errCount - er0 !== 1) $display("[TB] FAIL range_err_count: got %0d, required 1", errCount - er0);
        else passes++;
        checks++;
        if (lastErrCyc !== byteStart[3] + STROBE_DELAY + 1)
            $display("[TB] FAIL range_err_time: got cycle %0d, required %0d", lastErrCyc, byteStart[3] + STROBE_DELAY + 1);
        else passes++;
        checks++;
        if (fvCount - fv0 !== 0 || obsFields() !== expFields)
            $display("[TB] FAIL range_hold: got fields %h, required %h", obsFields(), expFields);
        else passes++;
        f = randomGoodFrame();
        fv0 = fvCount;
        sendFrame(f);
        expFields = fieldsOf(f);
        checks++;
        if (fvCount - fv0 !== 1 || obsFields() !== expFields)
            $display("[TB] FAIL range_recover: got fields %h, required %h", obsFields(), expFields);
        else passes++;
    endtask

    task automatic test_bad_stop();
        logic [7:0][7:0] f;
        int fv0, er0;
        fv0 = fvCount; er0 = errCount;
        sendBits(8'hFF, 1'b1);
        sendBits(8'h03, 1'b1);
        sendBits(8'h0C, 1'b1);
        sendBits(8'h22, 1'b1);
        sendBits(8'h05, 1'b0);
        repeat (3 * DIV) @(negedge clk);
        checks++;
        if (errCount - er0 !== 1) $display("[TB] FAIL stop_err_count: got %0d, required 1", errCount - er0);
        else passes++;
        checks++;
        if (lastErrCyc !== lastStartCyc + STROBE_DELAY + 1)
            $display("[TB] FAIL stop_err_time: got cycle %0d, required %0d", lastErrCyc, lastStartCyc + STROBE_DELAY + 1);
        else passes++;
        link.rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        f = randomGoodFrame();
        sendFrame(f);
        expFields = fieldsOf(f);
        checks++;
        if (fvCount - fv0 !== 1 || errCount - er0 !== 1)
            $display("[TB] FAIL stop_recover_counts: got valid %0d err %0d, required 1 and 1", fvCount - fv0, errCount - er0);
        else passes++;
        checks++;
        if (obsFields() !== expFields) $display("[TB] FAIL stop_recover_fields: got %h, required %h", obsFields(), expFields);
        else passes++;
    endtask

    task automatic test_glitch_resync();
        logic [7:0][7:0] f;
        int fv0, er0;
        fv0 = fvCount; er0 = errCount;
        @(negedge clk);
        link.rx = 1'b0;
        repeat (5) @(negedge clk);
        link.rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        checks++;
        if ((fvCount - fv0) + (errCount - er0) !== 0)
            $display("[TB] FAIL glitch_pulses: got %0d, required 0", (fvCount - fv0) + (errCount - er0));
        else passes++;
        sendBits(8'hFF, 1'b1);
        sendBits(8'h05, 1'b1);
        f = randomGoodFrame();
        sendFrame(f);
        expFields = fieldsOf(f);
        checks++;
        if (errCount - er0 !== 1) $display("[TB] FAIL resync_err_count: got %0d, required 1", errCount - er0);
        else passes++;
        checks++;
        if (fvCount - fv0 !== 1) $display("[TB] FAIL resync_valid_count: got %0d, required 1", fvCount - fv0);
        else passes++;
        checks++;
        if (obsFields() !== expFields) $display("[TB] FAIL resync_fields: got %h, required %h", obsFields(), expFields);
        else passes++;
    endtask

    task automatic test_gap_timeout();
        int fv0, er0;
        fv0 = fvCount; er0 = errCount;
        sendBits(8'hFF, 1'b1);
        sendBits(8'h02, 1'b1);
        sendBits(8'h10, 1'b1);
        sendBits(8'h20, 1'b1);
        sendBits(8'h30, 1'b1);
        repeat (3 * 10 * DIV) @(negedge clk);
        checks++;
        if (errCount - er0 !== 1) $display("[TB] FAIL gap_err_count: got %0d, required 1", errCount - er0);
        else passes++;
        checks++;
        if (lastErrCyc !== lastStartCyc + STROBE_DELAY + GAP_CYCLES)
            $display("[TB] FAIL gap_err_time: got cycle %0d, required %0d", lastErrCyc, lastStartCyc + STROBE_DELAY + GAP_CYCLES);
        else passes++;
        checks++;
        if (fvCount - fv0 !== 0 || obsFields() !== expFields)
            $display("[TB] FAIL gap_hold: got fields %h, required %h", obsFields(), expFields);
        else passes++;
    endtask

    task automatic test_random_frames();
        logic [7:0][7:0] f;
        int fv0, er0, k;
        bit good;
        for (int n = 0; n < 8; n++) begin
            f = randomGoodFrame();
            if ($urandom_range(0, 1) == 1) begin
                k = int'($urandom_range(1, 7));
                case (k)
                    1:       f[k] = 8'($urandom_range(8, 254));
                    2:       f[k] = 8'($urandom_range(24, 254));
                    5:       f[k] = 8'($urandom_range(64, 254));
                    default: f[k] = 8'($urandom_range(60, 254));
                endcase
            end
            good = frameGood(f);
            fv0 = fvCount; er0 = errCount;
            sendFrame(f);
            if (good) expFields = fieldsOf(f);
            checks++;
            if (fvCount - fv0 !== (good ? 1 : 0))
                $display("[TB] FAIL rand%0d_valid: got %0d, required %0d", n, fvCount - fv0, good ? 1 : 0);
            else passes++;
            checks++;
            if (errCount - er0 !== (good ? 0 : 1))
                $display("[TB] FAIL rand%0d_err: got %0d, required %0d", n, errCount - er0, good ? 0 : 1);
            else passes++;
            checks++;
            if (obsFields() !== expFields)
                $display("[TB] FAIL rand%0d_fields: got %h, required %h", n, obsFields(), expFields);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0][7:0] f1, f2;
        int fv0;
        f1 = randomGoodFrame();
        f2 = randomGoodFrame();
        fv0 = fvCount;
        for (int i = 0; i < 8; i++) sendBits(f1[i], 1'b1);
        for (int i = 0; i < 8; i++) sendBits(f2[i], 1'b1);
        repeat (4) @(negedge clk);
        expFields = fieldsOf(f2);
        checks++;
        if (fvCount - fv0 !== 2) $display("[TB] FAIL b2b_valid_count: got %0d, required 2", fvCount - fv0);
        else passes++;
        checks++;
        if (obsFields() !== expFields) $display("[TB] FAIL b2b_fields: got %h, required %h", obsFields(), expFields);
        else passes++;
    endtask

    task automatic test_midframe_reset();
        logic [7:0][7:0] f;
        logic [7:0] partial;
        int fv0, er0;
        partial = 8'h05;
        fv0 = fvCount; er0 = errCount;
        sendBits(8'hFF, 1'b1);
        sendBits(8'h03, 1'b1);
        sendBits(8'h0C, 1'b1);
        sendBits(8'h22, 1'b1);
        @(negedge clk);
        link.rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            link.rx = partial[i];
            repeat (DIV) @(negedge clk);
        end
        link.rx = partial[3];
        repeat (DIV / 2) @(negedge clk);
        rst_n = 1'b0;
        link.rx = 1'b1;
        repeat (3) @(negedge clk);
        expFields = '0;
        checks++;
        if (obsFields() !== 39'd0) $display("[TB] FAIL midreset_fields: got %h, required 0", obsFields());
        else passes++;
        rst_n = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        checks++;
        if ((fvCount - fv0) + (errCount - er0) !== 0)
            $display("[TB] FAIL midreset_pulses: got %0d, required 0", (fvCount - fv0) + (errCount - er0));
        else passes++;
        f = randomGoodFrame();
        sendFrame(f);
        expFields = fieldsOf(f);
        checks++;
        if (fvCount - fv0 !== 1 || errCount - er0 !== 0)
            $display("[TB] FAIL midreset_recover_counts: got valid %0d err %0d, required 1 and 0", fvCount - fv0, errCount - er0);
        else passes++;
        checks++;
        if (obsFields() !== expFields) $display("[TB] FAIL midreset_recover_fields: got %h, required %h", obsFields(), expFields);
        else passes++;
    endtask

    task automatic test_exclusive();
        checks++;
        if (bothHigh !== 0) $display("[TB] FAIL pulse_exclusive: got %0d overlapping cycles, required 0", bothHigh);
        else passes++;
    endtask

    initial begin
        link.rx = 1'b1;
        test_reset();
        test_basic();
        test_range_error();
        test_bad_stop();
        test_glitch_resync();
        test_gap_timeout();
        test_random_frames();
        test_back_to_back();
        test_midframe_reset();
        test_exclusive();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
